// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port BRAM with registered read data.
// Default round-robin; define BRAM_ARB_FIXED_PRIO_EN for fixed priority with anti-starvation.
module bram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    input  logic [2:0]            i_subaddr0,
    input  logic [2:0]            i_subaddr1,
    output logic                  o_ack0,
    output logic                  o_ack1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata0,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    output logic [2:0]            o_mem_wr_subaddr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    logic                  grant0, grant1;
    logic [3:0]            wait_cnt0, wait_cnt1;
    logic                  rd_pend0, rd_pend1;
    logic [DATA_WIDTH-1:0] rdata_q0, rdata_q1;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  unused_wait;

    assign unused_wait = ^{wait_cnt0, wait_cnt1};

`ifndef BRAM_ARB_FIXED_PRIO_EN
    logic last_grant;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant <= grant1;
        end
    end
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!i_rst) begin
            if (i_req0 && i_req1) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
                // a starved port 1 takes one turn, then its counter clears
                if (wait_cnt1 == 4'd15) grant1 = 1'b1;
                else                    grant0 = 1'b1;
`else
                if (last_grant) grant0 = 1'b1;
                else            grant1 = 1'b1;
`endif
            end else begin
                grant0 = i_req0;
                grant1 = i_req1;
            end
        end
    end

    assign o_ack0           = grant0;
    assign o_ack1           = grant1;
    assign o_mem_we         = (grant0 & i_we0) | (grant1 & i_we1);
    assign o_mem_addr       = grant1 ? i_addr1 : (grant0 ? i_addr0 : addr_q);
    assign o_mem_wdata      = grant1 ? i_wdata1 : i_wdata0;
    assign o_mem_wr_subaddr = grant1 ? i_subaddr1 : i_subaddr0;

    // RAM data arrives the cycle after the address; hold it once captured
    assign o_rvalid0 = rd_pend0;
    assign o_rvalid1 = rd_pend1;
    assign o_rdata0  = rd_pend0 ? i_mem_rdata : rdata_q0;
    assign o_rdata1  = rd_pend1 ? i_mem_rdata : rdata_q1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q   <= '0;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
            rdata_q0 <= '0;
            rdata_q1 <= '0;
        end else begin
            if (grant0 || grant1) addr_q <= o_mem_addr;
            rd_pend0 <= grant0 & ~i_we0;
            rd_pend1 <= grant1 & ~i_we1;
            if (rd_pend0) rdata_q0 <= i_mem_rdata;
            if (rd_pend1) rdata_q1 <= i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt0 <= 4'd0;
            wait_cnt1 <= 4'd0;
        end else begin
            if (grant0)                           wait_cnt0 <= 4'd0;
            else if (i_req0 && wait_cnt0 != 4'hf) wait_cnt0 <= wait_cnt0 + 4'd1;
            if (grant1)                           wait_cnt1 <= 4'd0;
            else if (i_req1 && wait_cnt1 != 4'hf) wait_cnt1 <= wait_cnt1 + 4'd1;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural registered-read RAM.
// Build with BRAM_ARB_FIXED_PRIO_EN to exercise fixed priority instead of round-robin.
module tb_bram_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        req0, req1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [2:0]  sub0, sub1;
    logic        ack0, ack1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [2:0]  mem_sub;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:4095];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 i_clk = ~i_clk;

    bram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(req0), .i_req1(req1),
        .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .i_subaddr0(sub0), .i_subaddr1(sub1),
        .o_ack0(ack0), .o_ack1(ack1),
        .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_we(mem_we), .o_mem_wr_subaddr(mem_sub),
        .i_mem_rdata(mem_rdata)
    );

    // read-before-write RAM: a read in the same cycle as a write sees old data
    always @(posedge i_clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'hA000_0000 + i;
        i_rst = 1;
        idle();
        addr0 = 12'h005; addr1 = 12'h000;
        wdata0 = '0; wdata1 = '0; sub0 = '0; sub1 = '0;
        req0 = 1;

        // reset state
        @(negedge i_clk);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        step();
        i_rst = 0;
        idle();

        // write then read-back on port 0
        req0 = 1; we0 = 1; addr0 = 12'h005; wdata0 = 32'hDEADBEEF; sub0 = 3'd3;
        @(negedge i_clk);
        check("wr_ack0", 32'(ack0), 32'd1);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'h005);
        check("wr_sub", 32'(mem_sub), 32'd3);
        check("wr_wdata", mem_wdata, 32'hDEADBEEF);
        check("wr_rvalid0", 32'(rvalid0), 32'd0);
        step();
        we0 = 0;
        @(negedge i_clk);
        check("rd_ack0", 32'(ack0), 32'd1);
        check("rd_we", 32'(mem_we), 32'd0);
        check("rd_no_rvalid_wr", 32'(rvalid0), 32'd0);
        step();
        idle();
        @(negedge i_clk);
        check("rd_rvalid0", 32'(rvalid0), 32'd1);
        check("rd_rdata0", rdata0, 32'hDEADBEEF);
        check("idle_addr_hold", 32'(mem_addr), 32'h005);
        check("idle_we", 32'(mem_we), 32'd0);
        step();
        @(negedge i_clk);
        check("rvalid0_drop", 32'(rvalid0), 32'd0);
        check("rdata0_hold", rdata0, 32'hDEADBEEF);

        i_rst = 1;
        step();
        i_rst = 0;

`ifdef BRAM_ARB_FIXED_PRIO_EN
        // both request continuously: 15 grants to port 0, then one to port 1
        addr0 = 12'h010; addr1 = 12'h020;
        req0 = 1; req1 = 1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge i_clk);
            check($sformatf("fp_ack0_c%0d", k), 32'(ack0), (k == 16) ? 32'd0 : 32'd1);
            check($sformatf("fp_ack1_c%0d", k), 32'(ack1), (k == 16) ? 32'd1 : 32'd0);
            step();
        end
        idle();
        step();
`else
        // round-robin contention from reset: 0,1,0,1
        addr0 = 12'h010; addr1 = 12'h020;
        for (int k = 0; k < 5; k++) begin
            req0 = (k < 4);
            req1 = (k < 4);
            @(negedge i_clk);
            if (k < 4) begin
                check($sformatf("rr_ack0_c%0d", k), 32'(ack0), (k % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("rr_ack1_c%0d", k), 32'(ack1), (k % 2 == 1) ? 32'd1 : 32'd0);
            end
            if (k >= 1) begin
                check($sformatf("rr_rv0_c%0d", k), 32'(rvalid0), ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("rr_rv1_c%0d", k), 32'(rvalid1), ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
                if ((k - 1) % 2 == 0) check($sformatf("rr_rd0_c%0d", k), rdata0, 32'hA000_0010);
                else                  check($sformatf("rr_rd1_c%0d", k), rdata1, 32'hA000_0020);
            end
            step();
        end
        idle();
`endif

        // reset lands in the cycle a port 1 read is acked
        req1 = 1; we1 = 0; addr1 = 12'h030;
        @(negedge i_clk);
        check("rst_mid_ack1", 32'(ack1), 32'd1);
        #1 i_rst = 1;
        #1;
        check("rst_mid_ack1_off", 32'(ack1), 32'd0);
        check("rst_mid_we", 32'(mem_we), 32'd0);
        idle();
        step();
        step();
        i_rst = 0;
        @(negedge i_clk);
        check("rst_rv1_a", 32'(rvalid1), 32'd0);
        step();
        @(negedge i_clk);
        check("rst_rv1_b", 32'(rvalid1), 32'd0);
        req0 = 1; req1 = 1; addr0 = 12'h011; addr1 = 12'h021;
        #1;
        check("post_rst_ack0", 32'(ack0), 32'd1);
        check("post_rst_ack1", 32'(ack1), 32'd0);
        step();
        idle();
        step();

        // single requester on port 1 streams 4 reads
        for (int k = 0; k < 5; k++) begin
            req1  = (k < 4);
            addr1 = 12'(k);
            @(negedge i_clk);
            if (k < 4) check($sformatf("s1_ack1_c%0d", k), 32'(ack1), 32'd1);
            if (k >= 1) begin
                check($sformatf("s1_rv1_c%0d", k), 32'(rvalid1), 32'd1);
                check($sformatf("s1_rd1_c%0d", k), rdata1, 32'hA000_0000 + 32'(k - 1));
            end
            step();
        end
        idle();
        @(negedge i_clk);
        check("s1_rv1_end", 32'(rvalid1), 32'd0);
        check("s1_rd1_hold", rdata1, 32'hA000_0003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
